// File: rtl/arm_mc_controller.sv
// Multicycle ARM control unit: main state machine, ALU decoder,
// condition logic with NZCV register, and write-enable gating.
//
// arm_mc_controller ports:
//   clk, reset          rising-edge clock, async active-low reset
//   Cond/Op/Funct/Rd    instruction fields from the IR
//   ALUFlags            NZCV from the ALU this cycle
//   PCWrite/IRWrite/RegWrite/MemWrite/BrL   gated write enables
//   AdrSrc/ResultSrc/ALUSrcA/ALUSrcB/ImmSrc/RegSrc   datapath selects
//   ALUControl          ALU operation
//   Flags               registered NZCV
//   State               current FSM state (debug)

module arm_mc_fsm #(
  parameter bit BL_EN = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] op,
  input  logic       imm,
  input  logic       link,
  input  logic       load,
  input  logic       skip_wb,
  output logic [3:0] state_code,
  output logic       in_exec,
  output logic       irw,
  output logic       next_pc,
  output logic       regw,
  output logic       memw,
  output logic       branch,
  output logic       brl,
  output logic       alu_op,
  output logic       adr_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_t;

  state_t state;
  state_t state_nx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_FETCH;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = S_FETCH;
    case (state)
      S_FETCH:  state_nx = S_DECODE;
      S_DECODE: begin
        case (op)
          2'b00:   state_nx = imm ? S_EXECI : S_EXECR;
          2'b01:   state_nx = S_MEMADR;
          2'b10:   state_nx = S_BRANCH;
          default: state_nx = S_FETCH;
        endcase
      end
      S_MEMADR: state_nx = load ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_nx = S_MEMWB;
      S_MEMWB:  state_nx = S_FETCH;
      S_MEMWR:  state_nx = S_FETCH;
      S_EXECR,
      S_EXECI:  state_nx = skip_wb ? S_FETCH : S_ALUWB;
      S_ALUWB:  state_nx = S_FETCH;
      S_BRANCH: state_nx = S_FETCH;
      default:  state_nx = S_FETCH;
    endcase
  end

  always_comb begin
    irw        = 1'b0;
    next_pc    = 1'b0;
    regw       = 1'b0;
    memw       = 1'b0;
    branch     = 1'b0;
    brl        = 1'b0;
    alu_op     = 1'b0;
    adr_src    = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    result_src = 2'b00;
    case (state)
      S_FETCH: begin
        irw        = 1'b1;
        next_pc    = 1'b1;
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
      end
      S_DECODE: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
      end
      S_MEMADR: alu_src_b = 2'b01;
      S_MEMRD:  adr_src   = 1'b1;
      S_MEMWB: begin
        result_src = 2'b01;
        regw       = 1'b1;
      end
      S_MEMWR: begin
        adr_src = 1'b1;
        memw    = 1'b1;
      end
      S_EXECR:  alu_op = 1'b1;
      S_EXECI: begin
        alu_src_b = 2'b01;
        alu_op    = 1'b1;
      end
      S_ALUWB:  regw = 1'b1;
      S_BRANCH: begin
        alu_src_b  = 2'b01;
        result_src = 2'b10;
        branch     = 1'b1;
        // BL: R14 gets the link value while the PC path keeps 10
        if (BL_EN && link) begin
          regw = 1'b1;
          brl  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign state_code = state;
  assign in_exec    = (state == S_EXECR) || (state == S_EXECI);

endmodule

// ALU decoder: maps Funct[4:1] to an ALU op and flag-write mask.
// Ports: alu_op, funct in; alu_ctl, flag_w, skip_wb out.
module arm_mc_aludec #(
  parameter bit SHIFT_EN = 1'b1
) (
  input  logic       alu_op,
  input  logic [4:0] funct,
  output logic [2:0] alu_ctl,
  output logic [1:0] flag_w,
  output logic       skip_wb
);

  logic is_add;
  logic is_sub;
  logic is_cmp;
  logic is_and;
  logic is_orr;
  logic is_mov;
  logic op_ok;

  assign is_add = (funct[4:1] == 4'b0100);
  assign is_sub = (funct[4:1] == 4'b0010);
  assign is_cmp = (funct[4:1] == 4'b1010);
  assign is_and = (funct[4:1] == 4'b0000);
  assign is_orr = (funct[4:1] == 4'b1100);
  assign is_mov = SHIFT_EN && (funct[4:1] == 4'b1101);
  assign op_ok  = is_add | is_sub | is_cmp
                | is_and | is_orr | is_mov;

  // CMP and unknown ops have nothing to write back
  assign skip_wb = is_cmp | ~op_ok;

  always_comb begin
    alu_ctl = 3'b000;
    flag_w  = 2'b00;
    if (alu_op) begin
      unique case (1'b1)
        is_add:          alu_ctl = 3'b000;
        is_sub | is_cmp: alu_ctl = 3'b001;
        is_and:          alu_ctl = 3'b010;
        is_orr:          alu_ctl = 3'b011;
        is_mov:          alu_ctl = 3'b100;
        default:         alu_ctl = 3'b000;
      endcase
      flag_w[1] = op_ok & (funct[0] | is_cmp);
      flag_w[0] = flag_w[1] & (is_add | is_sub | is_cmp);
    end
  end

endmodule

// Condition check against the registered NZCV, plus the register.
// Ports: clk, reset, cond, alu_flags, flag_w, upd in; flags, cond_ex out.
module arm_mc_cond (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond,
  input  logic [3:0] alu_flags,
  input  logic [1:0] flag_w,
  input  logic       upd,
  output logic [3:0] flags,
  output logic       cond_ex
);

  logic n;
  logic z;
  logic c;
  logic v;
  logic ge;

  assign n  = flags[3];
  assign z  = flags[2];
  assign c  = flags[1];
  assign v  = flags[0];
  assign ge = (n == v);

  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      4'b0000: cond_ex = z;
      4'b0001: cond_ex = ~z;
      4'b0010: cond_ex = c;
      4'b0011: cond_ex = ~c;
      4'b0100: cond_ex = n;
      4'b0101: cond_ex = ~n;
      4'b0110: cond_ex = v;
      4'b0111: cond_ex = ~v;
      4'b1000: cond_ex = c & ~z;
      4'b1001: cond_ex = ~c | z;
      4'b1010: cond_ex = ge;
      4'b1011: cond_ex = ~ge;
      4'b1100: cond_ex = ~z & ge;
      4'b1101: cond_ex = z | ~ge;
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags <= 4'b0000;
    end else if (upd && cond_ex) begin
      if (flag_w[1]) flags[3:2] <= alu_flags[3:2];
      if (flag_w[0]) flags[1:0] <= alu_flags[1:0];
    end
  end

endmodule

module arm_mc_controller #(
  parameter int ALUCW    = 3,
  parameter bit SHIFT_EN = 1'b1,
  parameter bit BL_EN    = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       Cond,
  input  logic [1:0]       Op,
  input  logic [5:0]       Funct,
  input  logic [3:0]       Rd,
  input  logic [3:0]       ALUFlags,
  output logic             PCWrite,
  output logic             AdrSrc,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             RegWrite,
  output logic             BrL,
  output logic [1:0]       ResultSrc,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ImmSrc,
  output logic [1:0]       RegSrc,
  output logic [ALUCW-1:0] ALUControl,
  output logic [3:0]       Flags,
  output logic [3:0]       State
);

  logic       in_exec;
  logic       irw;
  logic       next_pc;
  logic       regw;
  logic       memw;
  logic       branch;
  logic       brl;
  logic       alu_op;
  logic       skip_wb;
  logic       cond_ex;
  logic       pcs;
  logic [2:0] alu_ctl;
  logic [1:0] flag_w;

  arm_mc_fsm #(
    .BL_EN(BL_EN)
  ) u_fsm (
    .clk        (clk),
    .reset      (reset),
    .op         (Op),
    .imm        (Funct[5]),
    .link       (Funct[4]),
    .load       (Funct[0]),
    .skip_wb    (skip_wb),
    .state_code (State),
    .in_exec    (in_exec),
    .irw        (irw),
    .next_pc    (next_pc),
    .regw       (regw),
    .memw       (memw),
    .branch     (branch),
    .brl        (brl),
    .alu_op     (alu_op),
    .adr_src    (AdrSrc),
    .alu_src_a  (ALUSrcA),
    .alu_src_b  (ALUSrcB),
    .result_src (ResultSrc)
  );

  arm_mc_aludec #(
    .SHIFT_EN(SHIFT_EN)
  ) u_aludec (
    .alu_op  (alu_op),
    .funct   (Funct[4:0]),
    .alu_ctl (alu_ctl),
    .flag_w  (flag_w),
    .skip_wb (skip_wb)
  );

  arm_mc_cond u_cond (
    .clk       (clk),
    .reset     (reset),
    .cond      (Cond),
    .alu_flags (ALUFlags),
    .flag_w    (flag_w),
    .upd       (in_exec),
    .flags     (Flags),
    .cond_ex   (cond_ex)
  );

  always_comb begin
    ALUControl      = '0;
    ALUControl[2:0] = alu_ctl;
  end

  assign ImmSrc = Op;
  assign RegSrc = {Op == 2'b01, Op == 2'b10};

  // a write to R15 is steered to the PC, not the register file
  assign pcs = branch | (regw & (Rd == 4'b1111));

  assign PCWrite  = reset & (next_pc | (pcs & cond_ex));
  assign RegWrite = reset & regw & cond_ex & ~(pcs & ~brl);
  assign MemWrite = reset & memw & cond_ex;
  assign IRWrite  = reset & irw;
  assign BrL      = reset & brl;

endmodule

// File: doc/arm_mc_controller.md
Name: arm_mc_controller

Overview:
- Control unit for the multicycle ARM core, successor to the single-cycle decoder.
- Combines a state-machine main controller with an ALU decoder, a PC-write unit, and condition logic that holds its own NZCV flag register.
- Sequences FETCH/DECODE/EXECUTE/WRITEBACK over multiple cycles so one memory and one ALU are shared.
- Adds over the single-cycle decoder: CMP without writeback, optional BL link write, and full conditional execution.

Parameters:
ALUCW, 3, width of ALUControl; must be >=3; bits above [2] are driven 0
SHIFT_EN, 1, 1 = decode Funct[4:1]=1101 (MOV/shift) as ALUControl 100; 0 = treat as unsupported
BL_EN, 1, 1 = Funct[4] in branch class performs link write to R14; 0 = plain B

Ports:
clk  in  1  system clock, rising edge
reset  in  1  reset, asynchronous, active-low
Cond  in  4  Instr[31:28]
Op  in  2  Instr[27:26]
Funct  in  6  Instr[25:20]
Rd  in  4  Instr[15:12]
ALUFlags  in  4  NZCV from ALU, current cycle
PCWrite  out  1  PC register enable
AdrSrc  out  1  0 = PC, 1 = ALUOut as memory address
MemWrite  out  1  data memory write enable
IRWrite  out  1  instruction register enable
RegWrite  out  1  register file write enable
BrL  out  1  link write: dest R14, ResultSrc=11 selects link value
ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult, 11 link value
ALUSrcA  out  1  0 = RD1, 1 = PC
ALUSrcB  out  2  00 RD2/shifted, 01 ExtImm, 10 const 4
ImmSrc  out  2  Op (00 DP imm8, 01 mem imm12, 10 branch imm24)
RegSrc  out  2  bit0 = (Op==10), bit1 = (Op==01)
ALUControl  out  ALUCW  ALU operation
Flags  out  4  registered NZCV
State  out  4  current state encoding (debug)

Behaviour:
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9.
- Transitions:
  - FETCH->DECODE.
  - DECODE: Op=00 goes to EXECI if Funct[5], else EXECR. Op=01 -> MEMADR. Op=10 -> BRANCH. Op=11 -> FETCH.
  - MEMADR: Funct[0]=1 -> MEMRD, else MEMWR. MEMRD->MEMWB->FETCH. MEMWR->FETCH.
  - EXECR/EXECI: -> ALUWB, except CMP (Funct[4:1]=1010) or an unsupported Funct, which go -> FETCH. ALUWB->FETCH. BRANCH->FETCH.
- Unlisted state codes -> FETCH next cycle.
- Raw per-state controls (all others 0, ALU op ADD):
  - FETCH: IRWrite=1, NextPC=1, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, AdrSrc=0.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
  - MEMADR: ALUSrcB=01.
  - MEMRD: AdrSrc=1.
  - MEMWB: ResultSrc=01, RegW=1.
  - MEMWR: AdrSrc=1, MemW=1.
  - EXECR: ALUSrcB=00, ALUOp=1.
  - EXECI: ALUSrcB=01, ALUOp=1.
  - ALUWB: ResultSrc=00, RegW=1.
  - BRANCH: ALUSrcB=01, ResultSrc=10, Branch=1. If BL_EN & Funct[4], also RegW=1 and BrL=1; ResultSrc stays 10 for the PC path, and the datapath uses ResultSrc=11 for the R14 data port when BrL=1.
- ALU decoder (ALUOp=1), keyed on Funct[4:1]:
  - 0100 -> 000 (ADD); 0010 and 1010 -> 001 (SUB/CMP); 0000 -> 010 (AND); 1100 -> 011 (ORR); 1101 -> 100 (only if SHIFT_EN).
  - Any other value -> 000, with no flag write and no register write.
  - With ALUOp=0, ALUControl=000.
- FlagW:
  - FlagW[1] (NZ) = Funct[0]; for CMP, FlagW[1] is forced 1.
  - FlagW[0] (CV) = FlagW[1] & op is ADD/SUB/CMP.
- Condition logic:
  - CondEx is combinational from Cond and the Flags register, per ARM: EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL=1110 -> 1, 1111 -> 0.
  - Flags[3:2] load ALUFlags[3:2] on the rising edge when in EXECR/EXECI & FlagW[1] & CondEx.
  - Flags[1:0] load ALUFlags[1:0] under the same conditions with FlagW[0].
- Gating:
  - PCS = Branch | (RegW & Rd==1111).
  - PCWrite = NextPC | (PCS & CondEx).
  - RegWrite = RegW & CondEx & ~(PCS & ~BrL). A PC-destination write goes through PCWrite, not the register file.
  - MemWrite = MemW & CondEx.
- Reset (async, reset=0):
  - State=FETCH, Flags=0000 immediately.
  - PCWrite, IRWrite, RegWrite, MemWrite, BrL forced 0 while reset=0.
  - Mux selects show FETCH values.
  - Assertion mid-instruction aborts it with no further writes.
  - First FETCH begins on the first rising clk after reset deasserts.
- Latency in cycles: DP register/imm = 4 (CMP 3), LDR = 5, STR = 4, B/BL = 3, Op=11 = 2.

Test Plan:
- Reset low mid-cycle, then release -> State=0, Flags=0000, all enables 0 during reset; first clk gives IRWrite=1 and PCWrite=1.
- ADDS register (Cond=1110, Op=00, Funct=001001, Rd=0001), ALUFlags=0100 -> States 0,1,6,8,0; Flags=0100 after EXECR; RegWrite=1 only in ALUWB.
- CMP imm (Funct=110101), then BEQ (Cond=0000, Op=10, Funct=100000) with Z=1 -> CMP skips ALUWB (0,1,7,0); PCWrite=1 in BRANCH. Repeat with Z=0 -> PCWrite=0.
- LDR (Op=01, Funct=011001, Rd=0011) -> States 0,1,2,3,4,0; AdrSrc=1 in MEMRD; ResultSrc=01 and RegWrite=1 in MEMWB. LDR with Rd=1111 -> PCWrite=1, RegWrite=0 in MEMWB.
- STR with Cond=0001 (NE) and Z=1 -> MemWrite stays 0 in MEMWR; with Z=0 -> MemWrite=1 for exactly one cycle.
- BL (Op=10, Funct=110000, Cond=1110, BL_EN=1) -> BRANCH asserts PCWrite=1, RegWrite=1, BrL=1. Op=11 -> 0,1,0 with no writes. Funct[4:1]=1101 with SHIFT_EN=0 -> no RegWrite.
